// File: rtl/ufm_pkg.sv
// ---------------------------------------------------------------------------
// ufm_pkg
// Shared types and constants for the UFM page-request controller.
//   ufm_state_e : controller FSM states (IDLE, CMD, XFER, WAIT)
//   UFM_CMD_RD  : ufm_cmd_wr value for a read command
//   UFM_CMD_WR  : ufm_cmd_wr value for a write command
//   UFM_TMO_W   : width of the per-state idle/timeout counter
// ---------------------------------------------------------------------------
package ufm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        XFER = 2'd2,
        WAIT = 2'd3
    } ufm_state_e;

    localparam logic UFM_CMD_RD = 1'b0;
    localparam logic UFM_CMD_WR = 1'b1;

    localparam int UFM_TMO_W = 8;

endpackage

// File: rtl/req_edge_det.sv
// ---------------------------------------------------------------------------
// req_edge_det
// Enable-gated rising-edge detector for an already-synchronized request level.
//   sync_clk    : clock
//   sync_rst    : asynchronous active-high reset (history register cleared)
//   sync_clk_en : sampling enable; history only updates when high and a start
//                 can only be reported when high
//   req         : synchronized request level
//   start       : combinational one-cycle start indication
// ---------------------------------------------------------------------------
module req_edge_det (
    input  logic sync_clk,
    input  logic sync_rst,
    input  logic sync_clk_en,
    input  logic req,
    output logic start
);

    logic prev_reg;

    // History holds while disabled, so an edge that occurs during a disabled
    // stretch is still seen on the first enabled cycle.
    always_ff @(posedge sync_clk or posedge sync_rst) begin
        if (sync_rst) begin
            prev_reg <= 1'b0;
        end else if (sync_clk_en) begin
            prev_reg <= req;
        end
    end

    assign start = req & ~prev_reg & sync_clk_en;

endmodule

// File: rtl/ufm_page_req_ctrl.sv
// ---------------------------------------------------------------------------
// ufm_page_req_ctrl
// Turns rising edges of the synchronized read/write request levels into a
// single page command to the UFM flash, counts one page of data beats, waits
// for flash idle and reports completion (done) or idle timeout (err).
//
// Parameters: PAGE_BYTES (2..256), ADDR_W, TIMEOUT (1..255)
// Ports:
//   sync_clk, sync_rst      : clock, asynchronous active-high reset
//   sync_clk_en             : gates the request edge detectors only
//   rd_req, wr_req          : synchronized request levels
//   page_addr               : page address, captured at start
//   ufm_cmd_valid/_wr/_addr : command toward flash (wr: 1 = write)
//   ufm_cmd_ready           : flash accepts command
//   ufm_data_valid          : one byte beat transferred
//   ufm_busy                : flash internal operation in progress
//   byte_cnt                : beats counted in the current page
//   busy                    : controller not in IDLE
//   done, err               : one-cycle completion / timeout pulses
// ---------------------------------------------------------------------------
module ufm_page_req_ctrl
    import ufm_pkg::*;
#(
    parameter int PAGE_BYTES = 16,
    parameter int ADDR_W     = 9,
    parameter int TIMEOUT    = 255
) (
    input  logic              sync_clk,
    input  logic              sync_rst,
    input  logic              sync_clk_en,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] page_addr,
    output logic              ufm_cmd_valid,
    output logic              ufm_cmd_wr,
    output logic [ADDR_W-1:0] ufm_cmd_addr,
    input  logic              ufm_cmd_ready,
    input  logic              ufm_data_valid,
    input  logic              ufm_busy,
    output logic [7:0]        byte_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra bit so that PAGE_BYTES = 256 can be counted internally.
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0]     PAGE_LAST = CNT_W'(PAGE_BYTES - 1);
    localparam logic [CNT_W-1:0]     PAGE_FULL = CNT_W'(PAGE_BYTES);
    localparam logic [UFM_TMO_W-1:0] TMO_LIMIT = UFM_TMO_W'(TIMEOUT);

    // ---------------------------------------------------------------------
    // Request edge detection: index 0 = read, index 1 = write
    // ---------------------------------------------------------------------
    logic [1:0] req_vec;
    logic [1:0] start_vec;

    assign req_vec = {wr_req, rd_req};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            req_edge_det u_edge (
                .sync_clk    (sync_clk),
                .sync_rst    (sync_rst),
                .sync_clk_en (sync_clk_en),
                .req         (req_vec[gi]),
                .start       (start_vec[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    ufm_state_e            state_reg,    state_next;
    logic [CNT_W-1:0]      cnt_reg,      cnt_next;
    logic [UFM_TMO_W-1:0]  tmo_reg,      tmo_next;
    logic                  cmd_wr_reg,   cmd_wr_next;
    logic [ADDR_W-1:0]     cmd_addr_reg, cmd_addr_next;
    logic                  done_reg,     done_next;
    logic                  err_reg,      err_next;
    logic                  tmo_hit;

    always_ff @(posedge sync_clk or posedge sync_rst) begin
        if (sync_rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            tmo_reg      <= '0;
            cmd_wr_reg   <= 1'b0;
            cmd_addr_reg <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            tmo_reg      <= tmo_next;
            cmd_wr_reg   <= cmd_wr_next;
            cmd_addr_reg <= cmd_addr_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cmd_wr_next   = cmd_wr_reg;
        cmd_addr_next = cmd_addr_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        tmo_next      = tmo_reg;

        tmo_hit = (state_reg != IDLE) && (tmo_reg == TMO_LIMIT);

        // Valid is withdrawn in the cycle the timeout fires so a late
        // handshake can never be accepted for an aborted command.
        ufm_cmd_valid = (state_reg == CMD) && !tmo_hit;

        // Timeout has priority over every other transition, which also keeps
        // done and err mutually exclusive.
        if (tmo_hit) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start_vec[0] || start_vec[1]) begin
                        state_next    = CMD;
                        // Read wins a simultaneous edge; the write edge is lost.
                        cmd_wr_next   = start_vec[0] ? UFM_CMD_RD : UFM_CMD_WR;
                        cmd_addr_next = page_addr;
                        cnt_next      = '0;
                    end
                end
                CMD: begin
                    if (ufm_cmd_valid && ufm_cmd_ready) begin
                        state_next = XFER;
                    end
                end
                XFER: begin
                    if (ufm_data_valid) begin
                        if (cnt_reg < PAGE_FULL) begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                        if (cnt_reg == PAGE_LAST) begin
                            state_next = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!ufm_busy) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Idle counter: restarts on any progress (state change or beat).
        if ((state_next != state_reg) || ufm_data_valid) begin
            tmo_next = '0;
        end else if (state_reg != IDLE) begin
            tmo_next = tmo_reg + UFM_TMO_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ufm_cmd_wr   = cmd_wr_reg;
    assign ufm_cmd_addr = cmd_addr_reg;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign err          = err_reg;
    // With a 256-byte page the 8-bit port cannot show 256; it clamps at 255.
    assign byte_cnt     = cnt_reg[CNT_W-1] ? 8'hFF : cnt_reg[7:0];

endmodule

// File: tb/tb_ufm_page_req_ctrl.sv
module tb_ufm_page_req_ctrl;

    localparam int PAGE_BYTES = 16;
    localparam int ADDR_W     = 9;
    localparam int TIMEOUT    = 255;

    logic              sync_clk = 1'b0;
    logic              sync_rst;
    logic              sync_clk_en;
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] page_addr;
    logic              ufm_cmd_valid;
    logic              ufm_cmd_wr;
    logic [ADDR_W-1:0] ufm_cmd_addr;
    logic              ufm_cmd_ready;
    logic              ufm_data_valid;
    logic              ufm_busy;
    logic [7:0]        byte_cnt;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 sync_clk = ~sync_clk;

    ufm_page_req_ctrl #(
        .PAGE_BYTES (PAGE_BYTES),
        .ADDR_W     (ADDR_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .sync_clk       (sync_clk),
        .sync_rst       (sync_rst),
        .sync_clk_en    (sync_clk_en),
        .rd_req         (rd_req),
        .wr_req         (wr_req),
        .page_addr      (page_addr),
        .ufm_cmd_valid  (ufm_cmd_valid),
        .ufm_cmd_wr     (ufm_cmd_wr),
        .ufm_cmd_addr   (ufm_cmd_addr),
        .ufm_cmd_ready  (ufm_cmd_ready),
        .ufm_data_valid (ufm_data_valid),
        .ufm_busy       (ufm_busy),
        .byte_cnt       (byte_cnt),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Transaction monitor: records accepted commands and pulse counts.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    cmd_t cmd_log[$];
    int   done_seen = 0;
    int   err_seen  = 0;

    always @(negedge sync_clk) begin
        if (!sync_rst) begin
            if (ufm_cmd_valid && ufm_cmd_ready) begin
                cmd_t c;
                c.wr   = ufm_cmd_wr;
                c.addr = ufm_cmd_addr;
                cmd_log.push_back(c);
                $display("cmd accepted: wr=%0b addr=0x%03h", c.wr, c.addr);
            end
            if (done) done_seen++;
            if (err)  err_seen++;
            if (done || err) begin
                checks++;
                if (done && err) begin
                    errors++;
                    $display("FAIL done_err_exclusive: done=%b err=%b, required not both", done, err);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge sync_clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        sync_rst       = 1'b1;
        sync_clk_en    = 1'b1;
        rd_req         = 1'b0;
        wr_req         = 1'b1;   // level already high through reset
        page_addr      = 9'h1C3;
        ufm_cmd_ready  = 1'b0;
        ufm_data_valid = 1'b0;
        ufm_busy       = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr, byte_cnt, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b wr=%b addr=%h cnt=%0d busy=%b done=%b err=%b, required all 0",
                     ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr, byte_cnt, busy, done, err);
        end
        sync_rst = 1'b0;
        tick();
        // A high level at reset release starts on the first enabled cycle.
        checks++;
        if ({busy, ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr} !== {1'b1, 1'b1, 1'b1, 9'h1C3}) begin
            errors++;
            $display("FAIL reset_level_start: got busy=%b valid=%b wr=%b addr=%h, required 1 1 1 1c3",
                     busy, ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr);
        end
        sync_rst = 1'b1;
        wr_req   = 1'b0;
        tick();
        sync_rst = 1'b0;
        tick();
        $display("test_reset complete");
    endtask

    // ---------------------------------------------------------------------
    // One full page transaction checked against timing derived from the rules:
    // start -> CMD next cycle, handshake -> XFER next cycle, final beat ->
    // WAIT next cycle, done one cycle after ufm_busy is seen low in WAIT.
    task automatic run_txn(input logic is_wr, input logic both, input logic [ADDR_W-1:0] addr,
                           input int gate_cycles, input int rdy_dly, input int max_gap,
                           input int busy_len, input string tag);
        int   done0 = done_seen;
        int   err0  = err_seen;
        int   n0    = cmd_log.size();
        logic exp_wr = both ? 1'b0 : is_wr;
        cmd_t exp_cmd;

        page_addr = addr;
        if (gate_cycles > 0) sync_clk_en = 1'b0;
        if (both) begin
            rd_req = 1'b1;
            wr_req = 1'b1;
        end else if (is_wr) begin
            wr_req = 1'b1;
        end else begin
            rd_req = 1'b1;
        end
        for (int g = 0; g < gate_cycles; g++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s gated_no_start: busy=%b, required 0", tag, busy);
            end
        end
        sync_clk_en = 1'b1;
        tick();
        page_addr = ~addr;   // latched value must not follow the input
        checks++;
        if ({ufm_cmd_valid, busy, ufm_cmd_wr, ufm_cmd_addr} !== {1'b1, 1'b1, exp_wr, addr}) begin
            errors++;
            $display("FAIL %s cmd_issue: got valid=%b busy=%b wr=%b addr=%h, required 1 1 %b %h",
                     tag, ufm_cmd_valid, busy, ufm_cmd_wr, ufm_cmd_addr, exp_wr, addr);
        end
        repeat (rdy_dly) tick();
        checks++;
        if ({ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr} !== {1'b1, exp_wr, addr}) begin
            errors++;
            $display("FAIL %s cmd_hold: got valid=%b wr=%b addr=%h, required 1 %b %h",
                     tag, ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr, exp_wr, addr);
        end
        ufm_cmd_ready = 1'b1;
        tick();
        ufm_cmd_ready = 1'b0;
        checks++;
        if ({ufm_cmd_valid, busy, byte_cnt} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL %s xfer_entry: got valid=%b busy=%b cnt=%0d, required 0 1 0",
                     tag, ufm_cmd_valid, busy, byte_cnt);
        end
        ufm_busy = (busy_len > 0);
        for (int b = 0; b < PAGE_BYTES; b++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            ufm_data_valid = 1'b1;
            tick();
            ufm_data_valid = 1'b0;
            checks++;
            if (byte_cnt !== 8'(b + 1)) begin
                errors++;
                $display("FAIL %s beat_count: got %0d, required %0d", tag, byte_cnt, b + 1);
            end
        end
        // Now in WAIT.
        checks++;
        if ({busy, done, byte_cnt} !== {1'b1, 1'b0, 8'(PAGE_BYTES)}) begin
            errors++;
            $display("FAIL %s wait_entry: got busy=%b done=%b cnt=%0d, required 1 0 %0d",
                     tag, busy, done, byte_cnt, PAGE_BYTES);
        end
        for (int j = 0; j < busy_len; j++) begin
            tick();
            checks++;
            if ({busy, done, err} !== 3'b100) begin
                errors++;
                $display("FAIL %s busy_stretch: got busy=%b done=%b err=%b at %0d, required 1 0 0",
                         tag, busy, done, err, j);
            end
            if (j == busy_len - 1) ufm_busy = 1'b0;
        end
        tick();
        checks++;
        if ({done, busy, err, byte_cnt} !== {1'b1, 1'b0, 1'b0, 8'(PAGE_BYTES)}) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b busy=%b err=%b cnt=%0d, required 1 0 0 %0d",
                     tag, done, busy, err, byte_cnt, PAGE_BYTES);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_single: got done=%b, required 0", tag, done);
        end
        rd_req = 1'b0;
        if (!both) wr_req = 1'b0;
        tick();
        exp_cmd.wr   = exp_wr;
        exp_cmd.addr = addr;
        checks++;
        if ((done_seen - done0 != 1) || (err_seen != err0) || (cmd_log.size() != n0 + 1)) begin
            errors++;
            $display("FAIL %s txn_counts: got done=%0d err=%0d cmds=%0d, required 1 0 1",
                     tag, done_seen - done0, err_seen - err0, cmd_log.size() - n0);
        end else if (cmd_log[n0] !== exp_cmd) begin
            errors++;
            $display("FAIL %s txn_cmd: got wr=%b addr=%h, required wr=%b addr=%h",
                     tag, cmd_log[n0].wr, cmd_log[n0].addr, exp_cmd.wr, exp_cmd.addr);
        end
        $display("%s: wr=%0b addr=0x%03h rdy_dly=%0d busy_len=%0d done", tag, exp_wr, addr, rdy_dly, busy_len);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_read();
        run_txn(1'b0, 1'b0, 9'(27), 0, 0, 0, 0, "read_basic");
    endtask

    task automatic test_simultaneous();
        int n0;
        run_txn(1'b0, 1'b1, 9'h05A, 0, 0, 0, 0, "simul_edge");
        // wr_req is still high; no new edge, so nothing may start.
        n0 = cmd_log.size();
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || cmd_log.size() != n0) begin
            errors++;
            $display("FAIL simul_no_write: got busy=%b new_cmds=%0d, required 0 0", busy, cmd_log.size() - n0);
        end
        wr_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int d0 = done_seen;
        int e0 = err_seen;
        int n0 = cmd_log.size();
        page_addr = 9'($urandom_range(511, 0));
        rd_req    = 1'b1;
        tick();   // CMD entry cycle
        repeat (TIMEOUT - 1) tick();
        checks++;
        if ({ufm_cmd_valid, err} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_early: got valid=%b err=%b, required 1 0", ufm_cmd_valid, err);
        end
        tick();
        tick();   // TIMEOUT+1 cycles after CMD entry
        checks++;
        if ({err, done, ufm_cmd_valid, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_err: got err=%b done=%b valid=%b busy=%b, required 1 0 0 0",
                     err, done, ufm_cmd_valid, busy);
        end
        tick();
        rd_req = 1'b0;
        tick();
        checks++;
        if ((err_seen - e0 != 1) || (done_seen != d0) || (cmd_log.size() != n0)) begin
            errors++;
            $display("FAIL timeout_counts: got err=%0d done=%0d cmds=%0d, required 1 0 0",
                     err_seen - e0, done_seen - d0, cmd_log.size() - n0);
        end
        $display("test_timeout complete");
    endtask

    task automatic test_gating();
        run_txn(1'b1, 1'b0, 9'h133, 4, 2, 1, 3, "gated_write");
    endtask

    task automatic test_reset_mid_xfer();
        int d0, e0;
        rd_req    = 1'b1;
        page_addr = 9'h0F0;
        tick();
        ufm_cmd_ready = 1'b1;
        tick();
        ufm_cmd_ready  = 1'b0;
        ufm_data_valid = 1'b1;
        repeat (7) tick();
        ufm_data_valid = 1'b0;
        checks++;
        if (byte_cnt !== 8'd7) begin
            errors++;
            $display("FAIL rst_mid_precount: got %0d, required 7", byte_cnt);
        end
        d0 = done_seen;
        e0 = err_seen;
        #2 sync_rst = 1'b1;
        #1;
        checks++;
        if ({ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr, byte_cnt, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got valid=%b wr=%b addr=%h cnt=%0d busy=%b done=%b err=%b, required all 0",
                     ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr, byte_cnt, busy, done, err);
        end
        rd_req = 1'b0;
        tick();
        sync_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (done_seen != d0 || err_seen != e0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got done=%0d err=%0d busy=%b, required 0 0 0",
                     done_seen - d0, err_seen - e0, busy);
        end
        run_txn(1'b0, 1'b0, 9'h0A5, 0, 1, 0, 0, "after_reset");
    endtask

    task automatic test_busy_stretch();
        run_txn(1'b1, 1'b0, 9'h1FF, 0, 0, 0, 100, "busy_stretch");
    endtask

    task automatic test_back_to_back();
        int n0 = cmd_log.size();
        rd_req    = 1'b1;
        page_addr = 9'h011;
        tick();
        ufm_cmd_ready = 1'b1;
        tick();
        ufm_cmd_ready  = 1'b0;
        ufm_data_valid = 1'b1;
        repeat (PAGE_BYTES) tick();
        ufm_data_valid = 1'b0;
        ufm_busy       = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: got %b, required 1", done);
        end
        rd_req    = 1'b0;
        wr_req    = 1'b1;
        page_addr = 9'h122;
        tick();
        checks++;
        if ({busy, ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr, done} !== {1'b1, 1'b1, 1'b1, 9'h122, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second_start: got busy=%b valid=%b wr=%b addr=%h done=%b, required 1 1 1 122 0",
                     busy, ufm_cmd_valid, ufm_cmd_wr, ufm_cmd_addr, done);
        end
        ufm_cmd_ready = 1'b1;
        tick();
        ufm_cmd_ready  = 1'b0;
        ufm_data_valid = 1'b1;
        repeat (PAGE_BYTES) tick();
        ufm_data_valid = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || cmd_log.size() != n0 + 2) begin
            errors++;
            $display("FAIL b2b_second_done: got done=%b cmds=%0d, required 1 2", done, cmd_log.size() - n0);
        end
        wr_req = 1'b0;
        repeat (2) tick();
        $display("test_back_to_back complete");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_txn(1'($urandom_range(1, 0)), 1'b0, 9'($urandom_range(511, 0)),
                    $urandom_range(2, 0), $urandom_range(8, 0), $urandom_range(3, 0),
                    $urandom_range(10, 0), $sformatf("random_%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_simultaneous();
        test_timeout();
        test_gating();
        test_reset_mid_xfer();
        test_busy_stretch();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
